// File: rtl/mux_scan_reg.sv
// -----------------------------------------------------------------------------
// mux_scan_reg
//
// Registered W-bit, N-channel selector with a valid/ready output slot.
// Two ways to fill the slot:
//   * manual mode (SCAN=0): LOAD captures channel S on the next rising edge.
//   * scan mode   (SCAN=1): an internal pointer walks channels 0..N-1, one
//     capture every DIV cycles, pausing while the output slot is occupied.
//
// Parameters
//   W     data width of each channel and of Y
//   N     number of input channels (N >= 2)
//   SELW  select width, derived from N (leave at default)
//   DIV   scan-mode cycles between captures (DIV >= 1)
//
// Ports
//   CLK      in   clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   I        in   N*W packed channels, channel k at I[k*W +: W]
//   S        in   manual select index
//   LOAD     in   manual capture request (ignored while SCAN=1)
//   SCAN     in   1 = auto-scan, 0 = manual
//   READY    in   downstream accepts Y while VALID=1
//   Y        out  captured channel data
//   SEL_OUT  out  index of the channel held in Y
//   VALID    out  Y holds an unconsumed sample
//   WRAP     out  one-cycle pulse alongside a scan capture of channel N-1
//   ERR      out  one-cycle pulse after a rejected LOAD
//   PAR      out  even parity of Y
//
// Optional feature
//   MUX_SCAN_PARITY_EN  defined: PAR is registered with every capture as the
//                       XOR reduction of the captured data.
//                       undefined: PAR is tied to 0, no parity logic exists.
// -----------------------------------------------------------------------------
module mux_scan_reg #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int SELW = $clog2(N),
  parameter int DIV  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N*W-1:0]    I,
  input  logic [SELW-1:0]   S,
  input  logic              LOAD,
  input  logic              SCAN,
  input  logic              READY,
  output logic [W-1:0]      Y,
  output logic [SELW-1:0]   SEL_OUT,
  output logic              VALID,
  output logic              WRAP,
  output logic              ERR,
  output logic              PAR
);

  // Divider counter width; DIV=1 still needs a one-bit counter that stays 0.
  localparam int                CNTW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNTW-1:0]   CNT_MAX = CNTW'(DIV - 1);
  localparam logic [SELW-1:0]   PTR_MAX = SELW'(N - 1);
  // N in one extra bit so S can be range-checked even when N is a power of 2.
  localparam logic [SELW:0]     N_EXT   = (SELW + 1)'(N);

  // ---------------------------------------------------------------------------
  // Channel view of the packed input bus
  // ---------------------------------------------------------------------------
  logic [W-1:0] chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = I[k*W +: W];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]    y_q,     y_d;
  logic [SELW-1:0] sel_q,   sel_d;
  logic            valid_q, valid_d;
  logic            wrap_q,  wrap_d;
  logic            err_q,   err_d;
  logic [SELW-1:0] ptr_q,   ptr_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;

  // ---------------------------------------------------------------------------
  // Capture decision
  // ---------------------------------------------------------------------------
  logic            free;      // output slot can take a capture this cycle
  logic            s_ok;      // manual select addresses an existing channel
  logic            cap_en;    // a capture happens on the coming edge
  logic [SELW-1:0] cap_idx;   // channel being captured
  logic [W-1:0]    cap_data;

  assign free = !valid_q || READY;
  assign s_ok = ({1'b0, S} < N_EXT);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;

    if (SCAN) begin
      // Count up to DIV-1, then sit there until the slot frees up; the
      // capture then fires in the very cycle READY returns.
      if (cnt_q == CNT_MAX) begin
        if (free) begin
          cap_en  = 1'b1;
          cap_idx = ptr_q;
          cnt_d   = '0;
          wrap_d  = (ptr_q == PTR_MAX);
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Manual mode keeps the divider cleared so a later switch to scan
      // always waits a full DIV period before its first capture.
      cnt_d = '0;
      if (LOAD) begin
        if (s_ok && free) begin
          cap_en  = 1'b1;
          cap_idx = S;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Only reached with cap_idx < N: ptr_q never leaves 0..N-1 and S is
  // range-checked before it becomes the capture index.
  assign cap_data = chan[cap_idx];

  // ---------------------------------------------------------------------------
  // Output slot and scan pointer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    // A consumed sample empties the slot unless a capture refills it below.
    valid_d = valid_q && !READY;

    if (cap_en) begin
      y_d     = cap_data;
      sel_d   = cap_idx;
      valid_d = 1'b1;
      ptr_d   = (cap_idx == PTR_MAX) ? '0 : cap_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Y       = y_q;
  assign SEL_OUT = sel_q;
  assign VALID   = valid_q;
  assign WRAP    = wrap_q;
  assign ERR     = err_q;

  // ---------------------------------------------------------------------------
  // Optional parity of the held sample
  // ---------------------------------------------------------------------------
`ifdef MUX_SCAN_PARITY_EN
  logic par_q, par_d;

  // Registered alongside Y so PAR always describes the sample it travels with.
  always_comb begin
    par_d = par_q;
    if (cap_en) begin
      par_d = ^cap_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign PAR = par_q;
`else
  assign PAR = 1'b0;
`endif

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Registered, parametrised W-bit, N-channel selector. Successor to the combinational 8x1 bus mux in the ALU datapath.
- Adds a registered output with valid/ready handshake, a manual load mode and an automatic scan mode.
- Scan mode steps through all channels at a programmable rate, with a wrap pulse and an error flag.
- Feeds the ALU result/constant path and the display/test-pattern logic.

Parameters:
- W, 8, data width of each channel and of Y.
- N, 8, number of input channels; legal N >= 2.
- SELW, $clog2(N), select width (derived; do not override).
- DIV, 4, scan-mode cycles between captures; legal DIV >= 1.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- I  in  N*W  packed channel inputs; channel k occupies I[k*W +: W].
- S  in  SELW  manual select index.
- LOAD  in  1  manual capture request; sampled only when SCAN=0.
- SCAN  in  1  1 = auto-scan mode, 0 = manual mode.
- READY  in  1  downstream accepts Y when VALID=1.
- Y  out  W  captured channel data.
- SEL_OUT  out  SELW  index of the channel held in Y.
- VALID  out  1  Y holds an unconsumed sample.
- WRAP  out  1  one-cycle pulse on scan capture of channel N-1.
- ERR  out  1  one-cycle pulse on a rejected LOAD.
- PAR  out  1  parity of Y (see Optional Feature).

Behaviour:
- Reset (async, RST_N=0): immediately Y=0, SEL_OUT=0, VALID=0, WRAP=0, ERR=0, PAR=0, internal ptr=0, cnt=0. Reset asserted mid-operation discards any pending sample.
- free = !VALID || READY, i.e. the output slot can take a capture this cycle.
- Manual mode (SCAN=0):
  - cnt is held at 0.
  - Capture when LOAD && S<N && free: Y<=I[S], SEL_OUT<=S, VALID<=1, ptr<=(S+1) mod N.
  - LOAD && S>=N: ERR pulses; no state change.
  - LOAD && !free: ERR pulses; request dropped; Y/VALID hold.
- Scan mode (SCAN=1):
  - LOAD and S are ignored.
  - cnt increments each cycle until it reaches DIV-1, then holds there while !free.
  - Capture when cnt==DIV-1 && free: Y<=I[ptr], SEL_OUT<=ptr, VALID<=1, cnt<=0, ptr<=(ptr==N-1)?0:ptr+1.
  - WRAP=1 in the cycle after a capture of ptr==N-1 (coincident with the new VALID/Y).
- Steady scan with READY=1: one capture every DIV cycles; first capture DIV cycles after SCAN rises from the reset/0 state.
- Latency: Y, SEL_OUT and VALID update on the edge that samples the capture condition, i.e. 1 cycle from LOAD to Y.
- Handshake:
  - VALID&&READY consumes the sample.
  - If a capture occurs in the same cycle, VALID stays 1 with the new data (back-to-back, no bubble). Otherwise VALID<=0.
  - Y and SEL_OUT hold their values while VALID=1 && READY=0, regardless of changes on I.
- Mode switch:
  - SCAN 1->0 clears cnt; ptr is retained.
  - SCAN 0->1 starts counting from cnt=0, continuing from ptr.
  - An outstanding VALID sample is unaffected by a mode switch.
- Simultaneous capture and consume: capture wins on the data; VALID stays 1.
- WRAP and ERR are single-cycle pulses and default to 0 in all other cycles.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined: PAR is registered with each capture as the even parity (XOR reduction) of the captured channel data, so PAR always matches the Y it accompanies. PAR is reset to 0.
- Undefined: PAR is tied to 0 and no parity logic is built. The port list is identical in both builds.

Test Plan:
- Reset: RST_N=0 asserted mid-scan -> all outputs 0 within the same cycle. After release, no VALID until a capture.
- Manual: inputs ch0..7 = FF,FD,FC,FB,7A,99,0F,55; LOAD=1, S=5, READY=1 -> next cycle Y=0x99, SEL_OUT=5, VALID=1. PAR=0 with the macro; PAR=0 without it.
- Reject: N=6 build, LOAD with S=7 -> ERR pulse, VALID stays 0. LOAD with S=2 while VALID=1, READY=0 -> ERR pulse, Y unchanged.
- Scan: SCAN=1, DIV=4, READY=1 from reset -> captures at cycles 4,8,...,32 deliver Y=FF,FD,FC,FB,7A,99,0F,55. WRAP pulses with the 0x55 capture; the 9th capture yields 0xFF.
- Backpressure: in scan, hold READY=0 for 10 cycles after a capture -> Y frozen, cnt holds at 3. On READY=1, the next channel is captured in that same cycle with no bubble.
- Mode switch: manual LOAD S=3, then SCAN=1 -> first scan capture after 4 cycles is channel 4 (0x7A).
